// File: rtl/adc_cap_defs.sv
// Shared constants for the ADC waveform capture block: FSM state codes,
// default trigger settings and the re-arm level helper.
package adc_cap_defs;

  // Capture FSM state encodings
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ARM  = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_CAP  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  // Default trigger settings (offset-binary sample values)
  localparam logic [7:0]  TRIG_LEVEL_DEF   = 8'd128;
  localparam logic [7:0]  TRIG_HYST_DEF    = 8'd4;
  localparam logic [15:0] TRIG_TIMEOUT_DEF = 16'd65535;

  // Re-arm threshold: level minus hysteresis, clamped at zero
  function automatic logic [7:0] arm_level(input logic [7:0] level,
                                           input logic [7:0] hyst);
    return (level > hyst) ? (level - hyst) : 8'd0;
  endfunction

endpackage

// File: rtl/adc_clk_gen.sv
// Free-running ADC clock divider. Produces ad_clk (low for the first half
// of the divide period, high for the second) and a one-cycle strobe on the
// last clk of each period, which is the edge where ADC data is sampled.
module adc_clk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic ad_clk,
  output logic smp_stb
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(CLK_DIV / 2);

  logic [CW-1:0] div_cnt;

  // Divider counts 0..CLK_DIV-1 in every state, restarting only on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (div_cnt == LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + CW'(1);
    end
  end

  assign ad_clk  = (div_cnt >= HALF);
  assign smp_stb = (div_cnt == LAST);

endmodule

// File: rtl/adc_wave_capture.sv
// ADC waveform capture: clocks a parallel 8-bit ADC, decimates its samples,
// waits for a rising-edge level trigger with hysteresis (or a timeout), then
// writes one frame into an external dual-port RAM and reports min/max.
module adc_wave_capture
  import adc_cap_defs::*;
#(
  parameter int          CLK_DIV      = 4,
  parameter int          FRAME_LEN    = 1024,
  parameter int          ADDR_W       = 10,
  parameter logic [7:0]  TRIG_LEVEL   = TRIG_LEVEL_DEF,
  parameter logic [7:0]  TRIG_HYST    = TRIG_HYST_DEF,
  parameter logic [15:0] TRIG_TIMEOUT = TRIG_TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        decim,
  input  logic [7:0]        ad_data,
  output logic              ad_clk,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  output logic              frame_done,
  output logic              trig_forced,
  output logic [7:0]        max_val,
  output logic [7:0]        min_val
);

  localparam logic [7:0]        ARM_LVL  = arm_level(TRIG_LEVEL, TRIG_HYST);
  localparam logic [ADDR_W-1:0] PEN_ADDR = ADDR_W'(FRAME_LEN - 2);

  logic              smp_stb;
  logic [2:0]        state;
  logic [7:0]        decim_l;
  logic [7:0]        dec_cnt;
  logic [15:0]       tout_cnt;
  logic              active;
  logic [7:0]        smp_p0;
  logic              vld_p0;
  logic              forced_l;
  logic [7:0]        run_min;
  logic [7:0]        run_max;
  logic [7:0]        min_nxt;
  logic [7:0]        max_nxt;
  logic              trig_hit;
  logic              tout_hit;

  adc_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .ad_clk  (ad_clk),
    .smp_stb (smp_stb)
  );

  assign active   = (state == ST_ARM) || (state == ST_WAIT) || (state == ST_CAP);
  assign min_nxt  = (smp_p0 < run_min) ? smp_p0 : run_min;
  assign max_nxt  = (smp_p0 > run_max) ? smp_p0 : run_max;
  assign trig_hit = (state == ST_WAIT) && (smp_p0 >= TRIG_LEVEL);
  assign tout_hit = (tout_cnt == TRIG_TIMEOUT - 16'd1);

  // ---- stage p0: raw ADC sample register ----
  // Data path only: sample the ADC bus on the last clk of each ad_clk period
  always_ff @(posedge clk) begin
    if (smp_stb) begin
      smp_p0 <= ad_data;
    end
  end

  // Decimation: flag one of every decim_l+1 raw samples as kept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_cnt <= '0;
      vld_p0  <= 1'b0;
    end else begin
      vld_p0 <= 1'b0;
      if (state == ST_IDLE && start) begin
        dec_cnt <= '0;
      end else if (smp_stb && active) begin
        if (dec_cnt == decim_l) begin
          dec_cnt <= '0;
          vld_p0  <= 1'b1;
        end else begin
          dec_cnt <= dec_cnt + 8'd1;
        end
      end
    end
  end

  // ---- stage p1: trigger FSM, RAM write port and min/max ----
  // Capture FSM; the trigger sample itself is written at address 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      decim_l     <= '0;
      tout_cnt    <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      trig_forced <= 1'b0;
      forced_l    <= 1'b0;
      run_min     <= 8'hFF;
      run_max     <= 8'h00;
      min_val     <= 8'hFF;
      max_val     <= 8'h00;
    end else begin
      wr_en      <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            decim_l     <= decim;
            tout_cnt    <= '0;
            busy        <= 1'b1;
            trig_forced <= 1'b0;
            forced_l    <= 1'b0;
            run_min     <= 8'hFF;
            run_max     <= 8'h00;
            state       <= ST_ARM;
          end
        end
        ST_ARM, ST_WAIT: begin
          if (vld_p0) begin
            tout_cnt <= tout_cnt + 16'd1;
            if (trig_hit || tout_hit) begin
              // A genuine level crossing wins over a coincident timeout
              forced_l <= !trig_hit;
              wr_en    <= 1'b1;
              wr_addr  <= '0;
              wr_data  <= smp_p0;
              run_min  <= min_nxt;
              run_max  <= max_nxt;
              state    <= ST_CAP;
            end else if (state == ST_ARM && smp_p0 < ARM_LVL) begin
              state <= ST_WAIT;
            end
          end
        end
        ST_CAP: begin
          if (vld_p0) begin
            wr_en   <= 1'b1;
            wr_addr <= wr_addr + ADDR_W'(1);
            wr_data <= smp_p0;
            run_min <= min_nxt;
            run_max <= max_nxt;
            if (wr_addr == PEN_ADDR) begin
              state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          frame_done  <= 1'b1;
          busy        <= 1'b0;
          min_val     <= run_min;
          max_val     <= run_max;
          trig_forced <= forced_l;
          state       <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_wave_capture.sv
// Bench for adc_wave_capture: an ADC model drives ramp or DC data on ad_clk,
// and each frame is checked against expectations derived from the trigger,
// decimation and framing rules (data sequence, spacing, min/max, flags).
module tb_adc_wave_capture;

  localparam int CLK_DIV   = 4;
  localparam int FRAME_LEN = 1024;
  localparam int ADDR_W    = 10;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start_a = 1'b0;
  logic              start_b = 1'b0;
  logic [7:0]        decim = 8'd0;
  logic [7:0]        ad_data = 8'd0;

  logic              a_ad_clk, a_wr_en, a_busy, a_frame_done, a_trig_forced;
  logic [ADDR_W-1:0] a_wr_addr;
  logic [7:0]        a_wr_data, a_max_val, a_min_val;
  logic              b_ad_clk, b_wr_en, b_busy, b_frame_done, b_trig_forced;
  logic [ADDR_W-1:0] b_wr_addr;
  logic [7:0]        b_wr_data, b_max_val, b_min_val;

  logic              sel = 1'b0;
  logic              o_ad_clk, o_wr_en, o_busy, o_frame_done, o_trig_forced;
  logic [ADDR_W-1:0] o_wr_addr;
  logic [7:0]        o_wr_data, o_max_val, o_min_val;

  int vectors = 0;
  int miscompares = 0;

  // ADC model state
  logic       dc_mode = 1'b0;
  logic [7:0] dc_val = 8'd0;
  logic [7:0] ramp_base = 8'd0;
  logic [7:0] ramp_cnt = 8'd0;

  always #5 clk = ~clk;

  adc_wave_capture #(
    .CLK_DIV   (CLK_DIV),
    .FRAME_LEN (FRAME_LEN),
    .ADDR_W    (ADDR_W)
  ) dut_a (
    .clk (clk), .rst_n (rst_n), .start (start_a), .decim (decim),
    .ad_data (ad_data), .ad_clk (a_ad_clk), .wr_en (a_wr_en),
    .wr_addr (a_wr_addr), .wr_data (a_wr_data), .busy (a_busy),
    .frame_done (a_frame_done), .trig_forced (a_trig_forced),
    .max_val (a_max_val), .min_val (a_min_val)
  );

  adc_wave_capture #(
    .CLK_DIV      (CLK_DIV),
    .FRAME_LEN    (FRAME_LEN),
    .ADDR_W       (ADDR_W),
    .TRIG_TIMEOUT (16'd16)
  ) dut_b (
    .clk (clk), .rst_n (rst_n), .start (start_b), .decim (decim),
    .ad_data (ad_data), .ad_clk (b_ad_clk), .wr_en (b_wr_en),
    .wr_addr (b_wr_addr), .wr_data (b_wr_data), .busy (b_busy),
    .frame_done (b_frame_done), .trig_forced (b_trig_forced),
    .max_val (b_max_val), .min_val (b_min_val)
  );

  assign o_ad_clk      = sel ? b_ad_clk      : a_ad_clk;
  assign o_wr_en       = sel ? b_wr_en       : a_wr_en;
  assign o_wr_addr     = sel ? b_wr_addr     : a_wr_addr;
  assign o_wr_data     = sel ? b_wr_data     : a_wr_data;
  assign o_busy        = sel ? b_busy        : a_busy;
  assign o_frame_done  = sel ? b_frame_done  : a_frame_done;
  assign o_trig_forced = sel ? b_trig_forced : a_trig_forced;
  assign o_max_val     = sel ? b_max_val     : a_max_val;
  assign o_min_val     = sel ? b_min_val     : a_min_val;

  // ADC model: a new conversion result appears shortly after each ad_clk rise
  always @(posedge a_ad_clk) begin
    #1;
    if (dc_mode) begin
      ad_data = dc_val;
    end else begin
      ad_data  = ramp_base + ramp_cnt;
      ramp_cnt = ramp_cnt + 8'd1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input bit use_b);
    if (use_b) start_b = 1'b1;
    else       start_a = 1'b1;
  endtask

  // Run one capture on the selected DUT and check every write against the model
  task automatic run_frame(input bit use_b, input int d, input bit exp_forced,
                           input int abort_at, input bit mid_start, input bit mid_decim);
    int         nw, cyc, last_cyc, fd_seen, extra_wr, extra_fd;
    logic [7:0] first, ev, mn, mx;
    sel   = use_b;
    decim = 8'(d);
    if (!dc_mode) ramp_base = 8'($urandom);
    @(negedge clk);
    pulse_start(use_b);
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    chk("busy_after_start", o_busy, 1);
    nw = 0; cyc = 0; last_cyc = 0; fd_seen = 0;
    first = 8'd0; mn = 8'hFF; mx = 8'h00;
    while (nw < FRAME_LEN && cyc < 40000) begin
      @(negedge clk);
      cyc++;
      start_a = 1'b0;
      start_b = 1'b0;
      if (o_frame_done) fd_seen++;
      if (o_wr_en) begin
        if (nw == 0) begin
          first = o_wr_data;
          ev    = first;
          if (dc_mode) chk("first_data_dc", first, dc_val);
          else         chk("trig_value_in_range",
                           (int'(first) >= 128 && int'(first) <= 128 + d), 1);
        end else begin
          chk("wr_spacing", cyc - last_cyc, CLK_DIV * (d + 1));
          ev = dc_mode ? dc_val : 8'(int'(first) + nw * (d + 1));
        end
        chk("wr_addr", o_wr_addr, nw);
        chk("wr_data", o_wr_data, ev);
        chk("busy_in_frame", o_busy, 1);
        if (ev < mn) mn = ev;
        if (ev > mx) mx = ev;
        last_cyc = cyc;
        nw++;
        if (mid_start && nw == 300) pulse_start(use_b);
        if (mid_decim && nw == 200) decim = 8'(d + 2);
        if (abort_at > 0 && nw == abort_at) begin
          rst_n = 1'b0;
          #1;
          chk("rst_wr_en", o_wr_en, 0);
          chk("rst_busy", o_busy, 0);
          chk("rst_wr_addr", o_wr_addr, 0);
          chk("rst_wr_data", o_wr_data, 0);
          chk("rst_min", o_min_val, 8'hFF);
          chk("rst_max", o_max_val, 8'h00);
          chk("rst_trig_forced", o_trig_forced, 0);
          repeat (3) begin
            @(negedge clk);
            chk("rst_no_done", o_frame_done, 0);
          end
          rst_n = 1'b1;
          return;
        end
      end
    end
    chk("write_count", nw, FRAME_LEN);
    if (nw != FRAME_LEN) return;
    @(negedge clk);
    chk("frame_done_after_last", o_frame_done, 1);
    chk("wr_en_after_last", o_wr_en, 0);
    chk("early_frame_done", fd_seen, 0);
    chk("min_val", o_min_val, mn);
    chk("max_val", o_max_val, mx);
    chk("trig_forced", o_trig_forced, exp_forced);
    chk("busy_cleared", o_busy, 0);
    extra_wr = 0; extra_fd = 0;
    repeat (40) begin
      @(negedge clk);
      if (o_wr_en) extra_wr++;
      if (o_frame_done) extra_fd++;
    end
    chk("extra_writes", extra_wr, 0);
    chk("extra_frame_done", extra_fd, 0);
    chk("min_hold", o_min_val, mn);
    chk("max_hold", o_max_val, mx);
  endtask

  initial begin
    bit prev, found;
    // Reset and idle behaviour
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("idle_a_wr_en", a_wr_en, 0);
    chk("idle_a_busy", a_busy, 0);
    chk("idle_a_done", a_frame_done, 0);
    chk("idle_a_min", a_min_val, 8'hFF);
    chk("idle_a_max", a_max_val, 8'h00);
    chk("idle_a_forced", a_trig_forced, 0);
    chk("idle_b_busy", b_busy, 0);
    chk("idle_b_min", b_min_val, 8'hFF);
    chk("idle_b_max", b_max_val, 8'h00);
    sel = 1'b0;
    prev = o_ad_clk;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (!prev && o_ad_clk) found = 1'b1;
      prev = o_ad_clk;
    end
    chk("ad_clk_rises", found, 1);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk("ad_clk_pattern", o_ad_clk, (k % 4) < 2);
    end
    chk("idle_wr_en_later", a_wr_en | b_wr_en, 0);
    chk("idle_busy_later", a_busy | b_busy, 0);
    chk("idle_done_later", a_frame_done | b_frame_done, 0);

    // Ramp, no decimation
    dc_mode = 1'b0;
    run_frame(1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
    // Ramp, decim=1, decim changed mid-frame
    run_frame(1'b0, 1, 1'b0, 0, 1'b0, 1'b1);
    // DC below arm level and DC above trigger level: both forced by timeout
    dc_mode = 1'b1;
    dc_val  = 8'($urandom_range(0, 123));
    run_frame(1'b1, 0, 1'b1, 0, 1'b0, 1'b0);
    dc_val  = 8'($urandom_range(128, 255));
    run_frame(1'b1, 0, 1'b1, 0, 1'b0, 1'b0);
    // Ramp with a stray start during capture
    dc_mode = 1'b0;
    run_frame(1'b0, 0, 1'b0, 0, 1'b1, 1'b0);
    // Reset at write 500, then a full frame from address 0
    run_frame(1'b0, 0, 1'b0, 500, 1'b0, 1'b0);
    run_frame(1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
    // Random decimation
    run_frame(1'b0, int'($urandom_range(0, 2)), 1'b0, 0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/adc_wave_capture.md
Name: adc_wave_capture

Overview:
- Capture-side counterpart of the DDS/DAC output path: drives an 8-bit parallel ADC clock and samples its data.
- Waits for a rising-edge level trigger with hysteresis, then writes one frame of decimated samples into an external dual-port RAM.
- Reports min/max of the frame and pulses frame_done for downstream measurement logic (FFT, frequency and phase measurement).
- Runs on the 100 MHz system clock, as do the DDS channels.

Parameters:
- CLK_DIV, 4: clk cycles per ad_clk period; even, >=2.
- FRAME_LEN, 1024: samples per frame; power of two.
- ADDR_W, 10: log2(FRAME_LEN).
- TRIG_LEVEL, 8'd128: trigger threshold (unsigned offset-binary).
- TRIG_HYST, 8'd4: re-arm hysteresis below TRIG_LEVEL.
- TRIG_TIMEOUT, 16'd65535: kept samples without a trigger before a forced trigger.

Ports:
- clk  in  1  100 MHz system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a capture when idle
- decim  in  8  keep one of every decim+1 raw samples; latched at start
- ad_data  in  8  ADC parallel data
- ad_clk  out  1  ADC sample clock
- wr_en  out  1  RAM write strobe, one clk wide
- wr_addr  out  ADDR_W  RAM write address
- wr_data  out  8  RAM write data
- busy  out  1  high from accepted start until frame_done
- frame_done  out  1  one-cycle pulse after the last write
- trig_forced  out  1  the last frame was started by timeout; valid from frame_done until next start
- max_val  out  8  maximum sample of the last frame
- min_val  out  8  minimum sample of the last frame

Behaviour:
- Reset (async assert, sync release): outputs, counters and the FSM clear to 0 / IDLE.
  - Exceptions: min_val resets to 8'hFF; max_val resets to 8'h00.
  - A reset mid-frame aborts the frame with no frame_done.
- Clock divider:
  - div_cnt counts 0..CLK_DIV-1 continuously, free-running from reset in every state.
  - ad_clk = 1 when div_cnt >= CLK_DIV/2, else 0.
- Raw sample: ad_data is registered on the edge where div_cnt == CLK_DIV-1.
- Kept sample:
  - A decimation counter counts raw samples 0..decim_l.
  - A raw sample is kept when the counter equals decim_l; the counter then wraps to 0.
  - decim = 0 keeps every raw sample. decim_l is the value latched at start.
- FSM states: IDLE, ARM, WAIT_TRIG, CAPTURE, DONE.
  - IDLE: on start, latch decim, clear the decimation and timeout counters, set busy, go to ARM. start in any other state is ignored.
  - ARM: on a kept sample < TRIG_LEVEL-TRIG_HYST (saturating at 0), go to WAIT_TRIG.
  - WAIT_TRIG: on a kept sample >= TRIG_LEVEL, go to CAPTURE. That sample is written at address 0.
  - Timeout: the counter counts kept samples in ARM and WAIT_TRIG. When it reaches TRIG_TIMEOUT, the current kept sample is treated as the trigger, trig_forced is set, and the FSM goes to CAPTURE.
  - CAPTURE: each kept sample is written at wr_addr = 0..FRAME_LEN-1. After the write at address FRAME_LEN-1, go to DONE.
  - DONE: pulse frame_done for one cycle, clear busy, go to IDLE.
- Write timing:
  - wr_en, wr_addr and wr_data are registered and asserted in the cycle after the kept-sample register updates.
  - There are exactly FRAME_LEN wr_en pulses per frame, spaced CLK_DIV*(decim_l+1) cycles apart.
  - wr_addr does not advance past FRAME_LEN-1; it holds its value when idle.
- min/max:
  - Running registers reset to FF/00 on accepted start, updated on every written sample.
  - The outputs update in the same cycle as frame_done and hold until the next frame_done.
- frame_done and wr_en of the last sample: frame_done is asserted exactly one cycle after the final wr_en.

Decomposition:
- Shared header/package adc_cap_defs: FSM state encodings, default TRIG_LEVEL, TRIG_HYST and TRIG_TIMEOUT constants.
- Sub-module adc_clk_gen: divider plus ad_clk generation and the raw-sample strobe, parameter CLK_DIV.
- The FSM, decimation, trigger and min/max logic stay in adc_wave_capture.

Test Plan:
- Reset released, no start -> ad_clk period 4 clk (2 low, 2 high); wr_en, busy and frame_done stay 0; min_val=FF, max_val=00.
- Ramp ad_data 0..255 repeating, decim=0, start -> ARM releases at a value <124; first write is wr_addr=0, wr_data=128. Then exactly 1024 writes every 4 clk, data incrementing mod 256. frame_done follows 1 cycle after the last wr_en; min=0, max=255; trig_forced=0.
- Same ramp, decim=1 -> writes every 8 clk with data stepping by 2. Changing decim mid-frame has no effect.
- DC ad_data=100, TRIG_TIMEOUT=16 -> forced trigger after 16 kept samples. 1024 writes of 100; trig_forced=1; min=max=100.
- start pulsed again during CAPTURE -> ignored; the frame is still exactly 1024 writes with a single frame_done.
- rst_n low at write 500 -> all outputs return to reset values immediately, no frame_done. A new start after release captures a full frame from address 0.
